// File: rtl/multicycle_control_fsm.sv
// Multicycle CPU control unit: sequences fetch/decode/execute states and
// drives the datapath control word, retire pulse and retired-instruction count.
module multicycle_control_fsm #(
    parameter logic [5:0] OP_LW    = 6'h00,
    parameter logic [5:0] OP_SW    = 6'h01,
    parameter logic [5:0] OP_J     = 6'h02,
    parameter logic [5:0] OP_RTYPE = 6'h03,
    parameter logic [5:0] OP_BEQ   = 6'h04
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    input  logic [5:0]  opcode,
    input  logic        mem_ready,
    output logic [15:0] ctrl,
    output logic [3:0]  state,
    output logic        busy,
    output logic        done,
    output logic        halted,
    output logic [31:0] instr_count
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_REXEC  = 4'd7,
        S_RWB    = 4'd8,
        S_BEQ    = 4'd9,
        S_JMP    = 4'd10,
        S_HALT   = 4'd11
    } state_t;

    state_t      state_q, state_d;
    logic        done_q;
    logic [31:0] count_q;
    logic        retire;
    logic [15:0] ctrl_w;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= retire;
            if (retire)
                count_q <= count_q + 32'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        ctrl_w  = '0;
        case (state_q)
            S_IDLE: begin
                if (start)
                    state_d = S_FETCH;
            end
            S_FETCH: begin
                // pcwrite/irwrite only on the completing cycle: one strobe per access
                ctrl_w = mem_ready ? 16'h084A : 16'h0808;
                if (mem_ready)
                    state_d = S_DECODE;
            end
            S_DECODE: begin
                ctrl_w = 16'h1800;
                if (opcode == OP_LW || opcode == OP_SW)
                    state_d = S_MEMADR;
                else if (opcode == OP_RTYPE)
                    state_d = S_REXEC;
                else if (opcode == OP_BEQ)
                    state_d = S_BEQ;
                else if (opcode == OP_J)
                    state_d = S_JMP;
                else
                    state_d = S_HALT;
            end
            S_MEMADR: begin
                ctrl_w = 16'h3000;
                if (opcode == OP_LW)
                    state_d = S_MEMRD;
                else if (opcode == OP_SW)
                    state_d = S_MEMWR;
                else
                    state_d = S_HALT;
            end
            S_MEMRD: begin
                ctrl_w = 16'h000C;
                if (mem_ready)
                    state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ctrl_w  = 16'h4020;
                retire  = 1'b1;
                state_d = stop ? S_IDLE : S_FETCH;
            end
            S_MEMWR: begin
                ctrl_w = mem_ready ? 16'h0014 : 16'h0004;
                if (mem_ready) begin
                    retire  = 1'b1;
                    state_d = stop ? S_IDLE : S_FETCH;
                end
            end
            S_REXEC: begin
                ctrl_w  = 16'h2400;
                state_d = S_RWB;
            end
            S_RWB: begin
                ctrl_w  = 16'hC000;
                retire  = 1'b1;
                state_d = stop ? S_IDLE : S_FETCH;
            end
            S_BEQ: begin
                ctrl_w  = 16'h2281;
                retire  = 1'b1;
                state_d = stop ? S_IDLE : S_FETCH;
            end
            S_JMP: begin
                ctrl_w  = 16'h0102;
                retire  = 1'b1;
                state_d = stop ? S_IDLE : S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_HALT;
            end
        endcase
    end

    assign ctrl        = ctrl_w;
    assign state       = state_q;
    assign busy        = (state_q != S_IDLE) && (state_q != S_HALT);
    assign halted      = (state_q == S_HALT);
    assign done        = done_q;
    assign instr_count = count_q;

endmodule
